// File: rtl/mem_word_sequencer_pkg.sv
// Shared encodings for the multi-beat word <-> byte-wide Memory sequencer.
// Combinational constants only; no latency or backpressure of its own.
package mem_word_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic OP_LOAD       = 1'b0;
  localparam logic OP_STORE      = 1'b1;
  localparam logic ENDIAN_LITTLE = 1'b0;
  localparam logic ENDIAN_BIG    = 1'b1;
  localparam logic MEM_CS_ON     = 1'b0;
  localparam logic MEM_CS_OFF    = 1'b1;
  localparam logic MEM_WR_WRITE  = 1'b1;
  localparam logic MEM_WR_READ   = 1'b0;

  // A single-beat word still needs a 1-bit beat counter.
  function automatic int beat_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/mem_word_sequencer_lane.sv
// Maps a beat index and byte order to a byte lane and extracts that lane's byte.
// Purely combinational, zero latency, no backpressure.
module byte_lane_select
  import mem_word_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  localparam int N  = DATA_WIDTH / 8,
  localparam int BW = beat_width(N)
) (
  input  logic [BW-1:0]         beat,
  input  logic                  endian,
  input  logic [DATA_WIDTH-1:0] word,
  output logic [BW-1:0]         lane,
  output logic [7:0]            lane_byte
);

  always_comb begin
    lane      = (endian == ENDIAN_BIG) ? (BW'(N - 1) - beat) : beat;
    lane_byte = word[8*lane +: 8];
  end

endmodule

// File: rtl/mem_word_sequencer.sv
// Moves a DATA_WIDTH word to/from byte-wide Memory in N beats; Done one cycle after the last beat.
// No backpressure: Start is taken only in IDLE, Abort cancels a transfer at the next edge.
module mem_word_sequencer
  import mem_word_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  Abort,
  input  logic                  Op,
  input  logic                  Endian,
  input  logic [ADDR_WIDTH-1:0] BaseAddr,
  input  logic [DATA_WIDTH-1:0] WrData,
  output logic                  Busy,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] RdData,
  output logic [ADDR_WIDTH-1:0] Mem_Address,
  output logic [7:0]            Mem_Data,
  output logic                  Mem_WR,
  output logic                  Mem_CS,
  input  logic [7:0]            MemOut
);

  localparam int N  = DATA_WIDTH / 8;
  localparam int BW = beat_width(N);
  localparam logic [BW-1:0] LAST_BEAT = BW'(N - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [BW-1:0]           beat;
  logic                    op_q;
  logic                    endian_q;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   asm_q;
  logic [DATA_WIDTH-1:0]   asm_merged;
  logic [DATA_WIDTH-1:0]   rd_q;
  logic [BW-1:0]           lane;
  logic [7:0]              store_byte;

  byte_lane_select #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
    .beat      (beat),
    .endian    (endian_q),
    .word      (wdata_q),
    .lane      (lane),
    .lane_byte (store_byte)
  );

  always_ff @(posedge Clock) begin
    if (!Reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (Start) state_nxt = S_XFER;
      S_XFER: begin
        if (Abort)                  state_nxt = S_IDLE;
        else if (beat == LAST_BEAT) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // The incoming byte is merged combinationally so the final beat can land in RdData directly.
  always_comb begin
    asm_merged               = asm_q;
    asm_merged[8*lane +: 8]  = MemOut;
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      beat     <= '0;
      op_q     <= OP_LOAD;
      endian_q <= ENDIAN_LITTLE;
      base_q   <= '0;
      wdata_q  <= '0;
      asm_q    <= '0;
      rd_q     <= '0;
    end else begin
      if (state == S_IDLE && Start) begin
        beat     <= '0;
        op_q     <= Op;
        endian_q <= Endian;
        base_q   <= BaseAddr;
        wdata_q  <= WrData;
        asm_q    <= '0;
      end
      if (state == S_XFER) begin
        beat <= beat + BW'(1);
        if (op_q == OP_LOAD) begin
          asm_q <= asm_merged;
          if (beat == LAST_BEAT && !Abort) rd_q <= asm_merged;
        end
      end
    end
  end

  always_comb begin
    Mem_CS      = MEM_CS_OFF;
    Mem_WR      = MEM_WR_READ;
    Mem_Address = '0;
    Mem_Data    = 8'h00;
    Busy        = (state == S_XFER) || (state == S_DONE);
    Done        = (state == S_DONE);
    RdData      = rd_q;
    if (state == S_XFER) begin
      Mem_CS      = MEM_CS_ON;
      Mem_Address = base_q + ADDR_WIDTH'(beat);
      if (op_q == OP_STORE) begin
        Mem_WR   = MEM_WR_WRITE;
        Mem_Data = store_byte;
      end
    end
  end

endmodule

// File: tb/tb_mem_word_sequencer.sv
// Bench: 16-bit and 32-bit sequencers against byte-wide memories, checked every cycle against a transfer-level model.
module tb_mem_word_sequencer;

  typedef struct {
    int          cyc;
    logic        busy;
    logic        done;
    logic        cs;
    logic        wr;
    logic        dchk;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [31:0] rd;
  } exp_t;

  typedef struct {
    string       nm;
    int          sel;
    logic [15:0] ad;
    logic [31:0] v;
  } lit_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        a_rst_n, a_start, a_abort, a_op, a_endian;
  logic [15:0] a_base, a_wdata, a_rd, a_addr;
  logic        a_busy, a_done, a_wr, a_cs;
  logic [7:0]  a_mdata, a_memout;
  logic        b_rst_n, b_start, b_abort, b_op, b_endian;
  logic [15:0] b_base, b_addr;
  logic [31:0] b_wdata, b_rd;
  logic        b_busy, b_done, b_wr, b_cs;
  logic [7:0]  b_mdata, b_memout;

  mem_word_sequencer #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) dut_a (
    .Clock(clk), .Reset(a_rst_n), .Start(a_start), .Abort(a_abort), .Op(a_op),
    .Endian(a_endian), .BaseAddr(a_base), .WrData(a_wdata), .Busy(a_busy),
    .Done(a_done), .RdData(a_rd), .Mem_Address(a_addr), .Mem_Data(a_mdata),
    .Mem_WR(a_wr), .Mem_CS(a_cs), .MemOut(a_memout));

  mem_word_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut_b (
    .Clock(clk), .Reset(b_rst_n), .Start(b_start), .Abort(b_abort), .Op(b_op),
    .Endian(b_endian), .BaseAddr(b_base), .WrData(b_wdata), .Busy(b_busy),
    .Done(b_done), .RdData(b_rd), .Mem_Address(b_addr), .Mem_Data(b_mdata),
    .Mem_WR(b_wr), .Mem_CS(b_cs), .MemOut(b_memout));

  // Byte-wide memories: DUT writes at the edge, bench presets go through the same process.
  logic [7:0]  mem_a [0:65535];
  logic [7:0]  mem_b [0:65535];
  logic        pk_en = 1'b0;
  int          pk_u = 0;
  logic [15:0] pk_addr = '0;
  logic [7:0]  pk_dat = '0;

  always @(posedge clk) begin
    if (!a_cs && a_wr) mem_a[a_addr] <= a_mdata;
    if (pk_en && pk_u == 0) mem_a[pk_addr] <= pk_dat;
  end
  always @(posedge clk) begin
    if (!b_cs && b_wr) mem_b[b_addr] <= b_mdata;
    if (pk_en && pk_u == 1) mem_b[pk_addr] <= pk_dat;
  end
  assign a_memout = (!a_cs && !a_wr) ? mem_a[a_addr] : 8'h00;
  assign b_memout = (!b_cs && !b_wr) ? mem_b[b_addr] : 8'h00;

  exp_t        qa[$];
  exp_t        qb[$];
  lit_t        lq[$];
  logic [31:0] rd_track [2];
  logic        chk_en = 1'b0;
  int          checks = 0;
  int          errors = 0;

  function automatic exp_t idle_e(input logic [31:0] rd);
    exp_t e;
    e.cyc = 0; e.busy = 1'b0; e.done = 1'b0; e.cs = 1'b1; e.wr = 1'b0;
    e.dchk = 1'b1; e.addr = 16'h0; e.data = 8'h00; e.rd = rd;
    return e;
  endfunction

  task automatic push(input int u, input exp_t e);
    if (u == 0) qa.push_back(e);
    else        qb.push_back(e);
  endtask

  // Transfer-level model: beat k at cycle c0+k, address base+k, lane k (little) or n-1-k (big).
  // cut >= 0 ends the transfer after that beat (abort, or reset when cut_rst).
  task automatic expect_xfer(input int u, input int c0, input logic op, input logic endian,
                             input logic [15:0] base, input logic [31:0] wd,
                             input int cut, input logic cut_rst);
    int          n;
    int          lane;
    logic [31:0] word;
    logic [15:0] ad;
    exp_t        e;
    n    = (u == 0) ? 2 : 4;
    word = 32'h0;
    for (int k = 0; k < n; k++) begin
      lane   = endian ? (n - 1 - k) : k;
      ad     = base + 16'(k);
      e.cyc  = c0 + k; e.busy = 1'b1; e.done = 1'b0; e.cs = 1'b0; e.wr = op;
      e.addr = ad; e.dchk = op; e.data = op ? wd[8*lane +: 8] : 8'h00; e.rd = rd_track[u];
      push(u, e);
      if (!op) word[8*lane +: 8] = (u == 0) ? mem_a[ad] : mem_b[ad];
      if (k == cut) begin
        if (cut_rst) begin
          e = idle_e(32'h0); e.cyc = c0 + k + 1; push(u, e);
          rd_track[u] = 32'h0;
        end
        return;
      end
    end
    if (!op) rd_track[u] = word;
    e = idle_e(rd_track[u]); e.cyc = c0 + n; e.busy = 1'b1; e.done = 1'b1;
    push(u, e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h required %h", nm, cyc, act, req);
    end
  endtask

  int          ia = 0, ib = 0, il = 0;
  logic [31:0] rd_last_a = 32'h0, rd_last_b = 32'h0;

  always @(negedge clk) begin
    exp_t ea, eb;
    if (chk_en) begin
      while (ia < qa.size() && qa[ia].cyc < cyc) ia++;
      if (ia < qa.size() && qa[ia].cyc == cyc) begin ea = qa[ia]; ia++; end
      else ea = idle_e(rd_last_a);
      rd_last_a = ea.rd;
      chk("a_busy", {31'h0, a_busy}, {31'h0, ea.busy});
      chk("a_done", {31'h0, a_done}, {31'h0, ea.done});
      chk("a_cs",   {31'h0, a_cs},   {31'h0, ea.cs});
      chk("a_wr",   {31'h0, a_wr},   {31'h0, ea.wr});
      chk("a_addr", {16'h0, a_addr}, {16'h0, ea.addr});
      if (ea.dchk) chk("a_data", {24'h0, a_mdata}, {24'h0, ea.data});
      chk("a_rd",   {16'h0, a_rd},   ea.rd);

      while (ib < qb.size() && qb[ib].cyc < cyc) ib++;
      if (ib < qb.size() && qb[ib].cyc == cyc) begin eb = qb[ib]; ib++; end
      else eb = idle_e(rd_last_b);
      rd_last_b = eb.rd;
      chk("b_busy", {31'h0, b_busy}, {31'h0, eb.busy});
      chk("b_done", {31'h0, b_done}, {31'h0, eb.done});
      chk("b_cs",   {31'h0, b_cs},   {31'h0, eb.cs});
      chk("b_wr",   {31'h0, b_wr},   {31'h0, eb.wr});
      chk("b_addr", {16'h0, b_addr}, {16'h0, eb.addr});
      if (eb.dchk) chk("b_data", {24'h0, b_mdata}, {24'h0, eb.data});
      chk("b_rd",   b_rd,            eb.rd);
    end
    while (il < lq.size()) begin
      case (lq[il].sel)
        0:       chk(lq[il].nm, {16'h0, a_rd}, lq[il].v);
        1:       chk(lq[il].nm, b_rd, lq[il].v);
        2:       chk(lq[il].nm, {24'h0, mem_a[lq[il].ad]}, lq[il].v);
        default: chk(lq[il].nm, {24'h0, mem_b[lq[il].ad]}, lq[il].v);
      endcase
      il++;
    end
  end

  task automatic step(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic poke(input int u, input logic [15:0] ad, input logic [7:0] d);
    pk_u = u; pk_addr = ad; pk_dat = d; pk_en = 1'b1;
    step(1);
    pk_en = 1'b0;
  endtask

  task automatic lit(input string nm, input int sel, input logic [15:0] ad, input logic [31:0] v);
    lit_t l;
    l.nm = nm; l.sel = sel; l.ad = ad; l.v = v;
    lq.push_back(l);
  endtask

  task automatic drive(input int u, input logic st, input logic op, input logic en,
                       input logic [15:0] base, input logic [31:0] wd);
    if (u == 0) begin
      a_start = st; a_op = op; a_endian = en; a_base = base; a_wdata = wd[15:0];
    end else begin
      b_start = st; b_op = op; b_endian = en; b_base = base; b_wdata = wd;
    end
  endtask

  // Full transfer; operands are scrambled right after Start so only latched copies can be right.
  task automatic go(input int u, input logic op, input logic en,
                    input logic [15:0] base, input logic [31:0] wd);
    int n;
    n = (u == 0) ? 2 : 4;
    drive(u, 1'b1, op, en, base, wd);
    expect_xfer(u, cyc + 1, op, en, base, wd, -1, 1'b0);
    step(1);
    drive(u, 1'b0, ~op, ~en, ~base, ~wd);
    step(n + 1);
  endtask

  initial begin
    int c;
    rd_track[0] = 32'h0; rd_track[1] = 32'h0;
    a_rst_n = 1'b0; b_rst_n = 1'b0; a_abort = 1'b0; b_abort = 1'b0;
    drive(0, 1'b1, 1'b1, 1'b0, 16'h0, 32'h0);
    drive(1, 1'b1, 1'b1, 1'b0, 16'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    step(1);
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    step(1);

    // 16-bit little-endian store
    go(0, 1'b1, 1'b0, 16'h0040, 32'h0000BEEF);
    lit("t1_mem40", 2, 16'h0040, 32'hEF);
    lit("t1_mem41", 2, 16'h0041, 32'hBE);
    lit("t1_rd", 0, 16'h0, 32'h0);
    step(1);

    // 16-bit big-endian load
    poke(0, 16'h0040, 8'h12);
    poke(0, 16'h0041, 8'h34);
    go(0, 1'b0, 1'b1, 16'h0040, 32'h0);
    lit("t2_rd", 0, 16'h0, 32'h1234);
    step(1);

    // 32-bit little-endian load wrapping past FFFF; Abort in IDLE must be ignored
    poke(1, 16'hFFFE, 8'hAA);
    poke(1, 16'hFFFF, 8'hBB);
    poke(1, 16'h0000, 8'hCC);
    poke(1, 16'h0001, 8'hDD);
    b_abort = 1'b1; step(1); b_abort = 1'b0;
    go(1, 1'b0, 1'b0, 16'hFFFE, 32'h0);
    lit("t3_rd", 1, 16'h0, 32'hDDCCBBAA);
    step(1);

    // 32-bit big-endian store
    go(1, 1'b1, 1'b1, 16'h0100, 32'h01020304);
    lit("be_mem100", 3, 16'h0100, 32'h01);
    lit("be_mem103", 3, 16'h0103, 32'h04);
    lit("be_rd_kept", 1, 16'h0, 32'hDDCCBBAA);
    step(1);

    // Start held high: second transfer begins in cycle 5
    c = cyc;
    drive(0, 1'b1, 1'b0, 1'b0, 16'h0040, 32'h0);
    expect_xfer(0, c + 1, 1'b0, 1'b0, 16'h0040, 32'h0, -1, 1'b0);
    expect_xfer(0, c + 5, 1'b0, 1'b0, 16'h0040, 32'h0, -1, 1'b0);
    step(5);
    a_start = 1'b0;
    step(3);
    lit("t4_rd", 0, 16'h0, 32'h3412);
    step(1);

    // 32-bit store aborted in beat 1
    poke(1, 16'h0202, 8'hEE);
    poke(1, 16'h0203, 8'hEE);
    c = cyc;
    drive(1, 1'b1, 1'b1, 1'b0, 16'h0200, 32'h55667788);
    expect_xfer(1, c + 1, 1'b1, 1'b0, 16'h0200, 32'h55667788, 1, 1'b0);
    step(1);
    b_start = 1'b0;
    step(1);
    b_abort = 1'b1;
    step(1);
    b_abort = 1'b0;
    step(2);
    lit("t5_mem200", 3, 16'h0200, 32'h88);
    lit("t5_mem201", 3, 16'h0201, 32'h77);
    lit("t5_mem202", 3, 16'h0202, 32'hEE);
    lit("t5_mem203", 3, 16'h0203, 32'hEE);
    lit("t5_rd", 1, 16'h0, 32'hDDCCBBAA);
    step(1);

    // Reset during beat 0 of a 16-bit load
    c = cyc;
    drive(0, 1'b1, 1'b0, 1'b0, 16'h0040, 32'h0);
    expect_xfer(0, c + 1, 1'b0, 1'b0, 16'h0040, 32'h0, 0, 1'b1);
    step(1);
    a_start = 1'b0;
    a_rst_n = 1'b0;
    step(1);
    a_rst_n = 1'b1;
    step(3);
    lit("t6_rd", 0, 16'h0, 32'h0);
    step(2);

    if (ia != qa.size() || ib != qb.size()) begin
      errors++;
      $display("FAIL sched: consumed a=%0d/%0d b=%0d/%0d", ia, qa.size(), ib, qb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
